// File: rtl/btn_pkg.sv
// Shared types and defaults for the paddle-game button conditioner.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        REL_DB
    } btn_state_t;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_THROW = 2;

    localparam int unsigned DEF_N_BTN         = 3;
    localparam int unsigned DEF_DB_CYCLES     = 500000;
    localparam int unsigned DEF_REPEAT_DELAY  = 20000000;
    localparam int unsigned DEF_REPEAT_PERIOD = 7500000;
    localparam logic [2:0]  DEF_REPEAT_MASK   = 3'b011;

    // Counter width able to hold the largest terminal count (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw pads / game logic and the conditioner.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = btn_pkg::DEF_N_BTN
) ();
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] evt_ack;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] held;
    logic [N_BTN-1:0] overrun;

    modport master (
        output btn_raw,
        output evt_ack,
        input  evt,
        input  held,
        input  overrun
    );

    modport slave (
        input  btn_raw,
        input  evt_ack,
        output evt,
        output held,
        output overrun
    );
endinterface

// File: rtl/btn_channel.sv
// One button: synchroniser, debounce/auto-repeat FSM and acknowledged event latch.
module btn_channel
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    input  logic evt_ack_i,
    output logic evt_o,
    output logic held_o,
    output logic overrun_o
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync1_q;
    logic             sync_q;
    btn_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             held_q;
    logic             evt_q;
    logic             overrun_q;

    logic             ev_c;
    logic             evt_d;
    logic             overrun_d;

    // Event raised this cycle: press accepted, first repeat, or periodic repeat.
    always_comb begin
        ev_c = 1'b0;
        if (sync_q) begin
            case (state_q)
                PRESS_DB: ev_c = (cnt_q == DB_LAST);
                HELD:     ev_c = REPEAT_EN && (cnt_q == DELAY_LAST);
                REPEAT:   ev_c = (cnt_q == PERIOD_LAST);
                default:  ev_c = 1'b0;
            endcase
        end
    end

    // Latch next values: a new event wins over a same-cycle ack.
    always_comb begin
        evt_d     = ev_c | (evt_q & ~evt_ack_i);
        overrun_d = overrun_q | (ev_c & evt_q & ~evt_ack_i);
    end

    // Synchroniser, FSM with per-state counter, and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            evt_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw_i ^ ACTIVE_LOW;
            sync_q    <= sync1_q;
            evt_q     <= evt_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (sync_q) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= HELD;
                        held_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync_q) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end else if (REPEAT_EN && (cnt_q == DELAY_LAST)) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!sync_q) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end else if (cnt_q == PERIOD_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REL_DB: begin
                    if (sync_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign evt_o     = evt_q;
    assign held_o    = held_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the left/right/throw buttons into held levels and acknowledged events.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned      N_BTN         = DEF_N_BTN,
    parameter bit               ACTIVE_LOW    = 1'b0,
    parameter int unsigned      DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned      REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned      REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic               CLK,
    input  logic               reset,
    btn_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] evt_w;
    logic [N_BTN-1:0] held_w;
    logic [N_BTN-1:0] overrun_w;

    // One independent channel per button.
    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_channel #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (reset),
            .btn_raw_i (bus.btn_raw[i]),
            .evt_ack_i (bus.evt_ack[i]),
            .evt_o     (evt_w[i]),
            .held_o    (held_w[i]),
            .overrun_o (overrun_w[i])
        );
    end

    assign bus.evt     = evt_w;
    assign bus.held    = held_w;
    assign bus.overrun = overrun_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized bench for btn_conditioner against a run-length reference model.
module tb_btn_conditioner;

    localparam int unsigned NB = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;
    localparam logic [2:0]  MASK = 3'b011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_conditioner_if #(.N_BTN(NB)) bus ();

    btn_conditioner #(
        .N_BTN         (NB),
        .ACTIVE_LOW    (1'b0),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .REPEAT_MASK   (MASK)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model state: raw delayed two edges, debounced level, event latch.
    logic [2:0] m_s1, m_s2, m_held, m_prev, m_evt, m_ovr;
    int unsigned m_run [3];
    int unsigned m_str [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        logic s, hp, ev;
        @(posedge clk);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_held = '0; m_prev = '0; m_evt = '0; m_ovr = '0;
            for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_str[i] = 0; end
        end else begin
            for (int i = 0; i < 3; i++) begin
                s  = m_s2[i];
                hp = m_held[i];
                ev = 1'b0;
                // Level flips after DB+1 consecutive samples disagreeing with it.
                if (s != hp) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_held[i] = s;
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                // Hold streak: edges held with input high, restarting after any low sample.
                if (!hp && m_held[i]) begin
                    m_str[i] = 0;
                    ev = 1'b1;
                end else if (hp && s) begin
                    if (!m_prev[i]) m_str[i] = 0;
                    else            m_str[i]++;
                    if (MASK[i] && m_str[i] >= RD && ((m_str[i] - RD) % RP) == 0) ev = 1'b1;
                end else begin
                    m_str[i] = 0;
                end
                m_prev[i] = s;
                if (ev) begin
                    if (m_evt[i] && !bus.evt_ack[i]) m_ovr[i] = 1'b1;
                    m_evt[i] = 1'b1;
                end else if (bus.evt_ack[i]) begin
                    m_evt[i] = 1'b0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.btn_raw;
        end
        edge_n++;
        #1;
        check("evt",     32'(bus.evt),     32'(m_evt));
        check("held",    32'(bus.held),    32'(m_held));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.btn_raw = '0;
        bus.evt_ack = '0;
        tick();
        tick();
        rst = 1'b0;
        edge_n = 0;
    endtask

    int rises[$];
    logic prev_bit;
    int hold_left [3];
    localparam int EXP_RISE [4] = '{7, 17, 22, 27};

    initial begin
        bus.btn_raw = '0;
        bus.evt_ack = '0;

        // Reset with all buttons pressed, then release reset.
        rst = 1'b1;
        bus.btn_raw = 3'b111;
        tick();
        check("rst_evt", 32'(bus.evt), 32'h0);
        tick();
        check("rst_all", 32'({bus.evt, bus.held, bus.overrun}), 32'h0);
        rst = 1'b0;
        edge_n = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 6) check("post_rst_e6", 32'(bus.evt), 32'h0);
            if (t == 7) check("post_rst_e7", 32'(bus.evt), 32'h7);
        end

        // Clean press on left with a single ack, then release.
        reset_dut();
        bus.btn_raw = 3'b001;
        for (int t = 1; t <= 22; t++) begin
            bus.evt_ack = (t == 10) ? 3'b001 : 3'b000;
            if (t == 13) bus.btn_raw = 3'b000;
            tick();
            if (t == 7)  check("press_held_e7", 32'(bus.held[0]), 32'h1);
            if (t == 7)  check("press_evt_e7",  32'(bus.evt[0]),  32'h1);
            if (t == 10) check("ack_clr_e10",   32'(bus.evt[0]),  32'h0);
            if (t == 18) check("rel_held_e18",  32'(bus.held[0]), 32'h1);
            if (t == 19) check("rel_held_e19",  32'(bus.held[0]), 32'h0);
        end
        bus.evt_ack = '0;

        // Short bounce on right is filtered.
        reset_dut();
        for (int t = 1; t <= 32; t++) begin
            bus.btn_raw = (t <= 2) ? 3'b010 : 3'b000;
            tick();
        end
        check("bounce", 32'({bus.evt, bus.held, bus.overrun}), 32'h0);

        // Auto-repeat on right with prompt acks.
        reset_dut();
        bus.btn_raw = 3'b010;
        rises.delete();
        prev_bit = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            bus.evt_ack = m_evt & 3'b010;
            tick();
            if (bus.evt[1] && !prev_bit) rises.push_back(t);
            prev_bit = bus.evt[1];
        end
        check("rep_count", 32'(rises.size()), 32'd4);
        for (int k = 0; k < 4 && k < rises.size(); k++) check("rep_edge", 32'(rises[k]), 32'(EXP_RISE[k]));

        // Throw never repeats.
        reset_dut();
        bus.btn_raw = 3'b100;
        rises.delete();
        prev_bit = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            bus.evt_ack = m_evt & 3'b100;
            tick();
            if (bus.evt[2] && !prev_bit) rises.push_back(t);
            prev_bit = bus.evt[2];
        end
        check("throw_count", 32'(rises.size()), 32'd1);
        if (rises.size() > 0) check("throw_edge", 32'(rises[0]), 32'd7);

        // Ack colliding with a repeat, then withheld acks cause overrun.
        reset_dut();
        bus.btn_raw = 3'b001;
        for (int t = 1; t <= 40; t++) begin
            bus.evt_ack = (t == 8 || t == 17) ? 3'b001 : 3'b000;
            if (t == 26) bus.btn_raw = 3'b000;
            tick();
            if (t == 17) check("coll_evt",  32'(bus.evt[0]),     32'h1);
            if (t == 17) check("coll_ovr",  32'(bus.overrun[0]), 32'h0);
            if (t == 21) check("ovr_e21",   32'(bus.overrun[0]), 32'h0);
            if (t == 22) check("ovr_e22",   32'(bus.overrun[0]), 32'h1);
        end
        check("ovr_sticky", 32'(bus.overrun[0]), 32'h1);

        // Reset in the middle of auto-repeat.
        reset_dut();
        bus.btn_raw = 3'b001;
        for (int t = 1; t <= 19; t++) begin
            bus.evt_ack = m_evt;
            tick();
        end
        bus.evt_ack = '0;
        rst = 1'b1;
        tick();
        check("mid_rst", 32'({bus.evt, bus.held, bus.overrun}), 32'h0);
        rst = 1'b0;
        edge_n = 0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 6) check("mid_rst_e6", 32'(bus.evt[0]), 32'h0);
            if (t == 7) check("mid_rst_e7", 32'(bus.evt[0]), 32'h1);
        end

        // Randomized traffic: mixed short bounces and long holds, random acks, rare resets.
        reset_dut();
        for (int i = 0; i < 3; i++) hold_left[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] == 0) begin
                    bus.btn_raw[i] = ~bus.btn_raw[i];
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                               : int'($urandom_range(1, 6));
                end else begin
                    hold_left[i]--;
                end
                bus.evt_ack[i] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
